ad7768_cfg_seq: RTL and testbench
=================================

// Module: ad7768_cfg_seq
// PURPOSE
//  Upstream register-configuration sequencer for the AD7768 dual-frame SPI engine.
//  - Walks a constant table of {addr, data} entries.
//  - Per entry, issues one engine job: frame 1 writes the register, frame 2 reads it back.
//  - Checks the readback, retries on mismatch, and reports done/error to the top-level control logic.
// PARAMETERS
//  NUM_REGS     8       table entries used (1..16)
//  MAX_RETRY    2       extra attempts per entry after a readback mismatch (0..7)
//  TIMEOUT_CYC  1023    clk cycles allowed in WAIT before spi_end is declared missing
//  VERIFY       1       1 = compare readback; 0 = skip compare, always advance
// PORTS
//  clk          in   1  system clock, 25 MHz
//  rst          in   1  synchronous, active-high reset
//  start        in   1  pulse; begins the sequence when idle
//  busy         out  1  high from accepted start until done/error is asserted
//  done         out  1  1-cycle pulse: all entries written and verified
//  error        out  1  level; set on retry exhaustion or timeout, cleared by start or rst
//  err_index    out  4  table index of the failing entry
//  err_code     out  2  0 none, 1 readback mismatch, 2 timeout
//  spi_start    out  1  1-cycle job request to the SPI engine
//  spi_addr1    out  8  frame-1 address, bit7 = 0
//  spi_rw1      out  1  frame-1 R/W flag, always 0 (write)
//  spi_data1    out  8  frame-1 data = table data
//  spi_addr2    out  8  frame-2 address = same table address
//  spi_rw2      out  1  frame-2 R/W flag, always 1 (read)
//  spi_data2    out  8  frame-2 data, always 8'h00
//  spi_end      in   1  1-cycle pulse from the engine: both frames complete
//  spi_rdata2   in   8  frame-2 captured byte; valid in the cycle spi_end is high
// BEHAVIOUR
//  Reset: all outputs 0; spi_* buses 0; state IDLE; index 0; retry count 0.
//  States and transitions:
//   - IDLE:  start -> LOAD; index <= 0, retry <= 0, error/err_code cleared.
//   - LOAD:  1 cycle. Registered table read; latch spi_addr1/2 and spi_data1. -> ISSUE.
//   - ISSUE: spi_start = 1 for exactly this cycle; clear timeout counter. -> WAIT.
//   - WAIT:  count clk cycles.
//       spi_end -> CHECK; rdata2 latched in that same cycle.
//       count == TIMEOUT_CYC -> FAIL, err_code 2.
//   - CHECK: if VERIFY == 0 or rdata2 == table data -> NEXT.
//       else if retry < MAX_RETRY: retry++ -> ISSUE (same entry, buses unchanged).
//       else FAIL, err_code 1.
//   - NEXT:  if index == NUM_REGS-1 -> DONE; else index++, retry <= 0 -> LOAD.
//   - DONE:  done = 1 for 1 cycle, busy = 0 -> IDLE.
//   - FAIL:  error = 1, err_index = index, busy = 0 -> IDLE.
//  Bus stability: spi_addr*/spi_data* are registered and change only in LOAD.
//   They are stable from ISSUE through CHECK.
//  Timing:
//   - busy rises the cycle after start is sampled.
//   - First spi_start occurs 2 cycles after start (IDLE->LOAD->ISSUE).
//   - Per-entry overhead beyond engine time is 4 cycles.
//  Boundary conditions:
//   - start while busy: ignored.
//   - start and rst in the same cycle: rst wins.
//   - spi_end outside WAIT: ignored.
//   - spi_end in the cycle the count reaches TIMEOUT_CYC: spi_end wins.
//   - rst mid-job: sequencer returns to IDLE immediately; spi_start is never re-issued.
//     The engine is reset by the same rst.
//   - Timeout counter is 10 bits and saturates; it does not wrap.
//   - NUM_REGS = 1: LOAD, ISSUE, WAIT, CHECK, NEXT, DONE with no index increment.
// STRUCTURE
//  Shared package ad7768_pkg:
//   - state encodings (one-hot, 8 states);
//   - err_code constants ERR_NONE/ERR_MISMATCH/ERR_TIMEOUT;
//   - register address constants (CH_STANDBY 8'h00, PWR_MODE 8'h04, DATA_CTRL 8'h06,
//     INTERFACE_CFG 8'h07).
//  Sub-module ad7768_cfg_rom: 4-bit index in, registered {addr[7:0], data[7:0]} out,
//   case-statement table.
// TESTING
//  Table used below: {04,1B},{07,01},{00,00}.
//  1. Happy path: responder echoes the written data. start -> 3 spi_start pulses with
//     addr1 04/07/00 and data1 1B/01/00; rw1 = 0, rw2 = 1 on every job; then done pulse,
//     error = 0.
//  2. Single mismatch: entry 1 returns 8'hFF once, then 8'h01 -> 4 spi_start total,
//     done = 1, error = 0.
//  3. Retry exhaustion (MAX_RETRY = 2): entry 2 always returns 8'hAA -> 3 jobs on entry 2,
//     then error = 1, err_index = 2, err_code = 1, no done.
//  4. Timeout: spi_end withheld on entry 0 -> error after TIMEOUT_CYC + 1 WAIT cycles,
//     err_code = 2, err_index = 0.
//  5. Reset mid-WAIT on entry 1, then start -> sequence restarts at addr 04 and completes.
//  6. start pulsed while busy and VERIFY = 0 with garbage readback -> exactly 3 jobs,
//     then done.

Source files
------------

// File: rtl/ad7768_pkg.sv
// Shared definitions for the AD7768 configuration sequencer: FSM encodings,
// error codes, register map constants and the table entry layout.
package ad7768_pkg;

    // One-hot state encodings
    localparam logic [7:0] S_IDLE  = 8'b0000_0001;
    localparam logic [7:0] S_LOAD  = 8'b0000_0010;
    localparam logic [7:0] S_ISSUE = 8'b0000_0100;
    localparam logic [7:0] S_WAIT  = 8'b0000_1000;
    localparam logic [7:0] S_CHECK = 8'b0001_0000;
    localparam logic [7:0] S_NEXT  = 8'b0010_0000;
    localparam logic [7:0] S_DONE  = 8'b0100_0000;
    localparam logic [7:0] S_FAIL  = 8'b1000_0000;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    localparam logic [7:0] CH_STANDBY    = 8'h00;
    localparam logic [7:0] PWR_MODE      = 8'h04;
    localparam logic [7:0] DATA_CTRL     = 8'h06;
    localparam logic [7:0] INTERFACE_CFG = 8'h07;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    // Bit 7 of a frame address is the R/W flag, so table addresses keep it clear.
    function automatic cfg_entry_t cfg_entry(input logic [7:0] addr, input logic [7:0] data);
        cfg_entry_t e;
        e.addr = {1'b0, addr[6:0]};
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/ad7768_cfg_rom.sv
// Constant register-configuration table with a registered read port.
// Output is {addr[7:0], data[7:0]} for the index presented on the previous cycle.
module ad7768_cfg_rom
    import ad7768_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  idx,
    output logic [15:0] entry
);

    cfg_entry_t entry_d;
    cfg_entry_t entry_q;

    always_comb begin
        entry_d = '0;
        case (idx)
            4'd0:    entry_d = cfg_entry(PWR_MODE,      8'h1B);
            4'd1:    entry_d = cfg_entry(INTERFACE_CFG, 8'h01);
            4'd2:    entry_d = cfg_entry(CH_STANDBY,    8'h00);
            4'd3:    entry_d = cfg_entry(8'h01,         8'h0D);
            4'd4:    entry_d = cfg_entry(8'h02,         8'h0D);
            4'd5:    entry_d = cfg_entry(8'h03,         8'h00);
            4'd6:    entry_d = cfg_entry(8'h05,         8'h08);
            // SPI_SYNC pulse last so the new settings take effect together
            4'd7:    entry_d = cfg_entry(DATA_CTRL,     8'h80);
            default: entry_d = '0;
        endcase
    end

    // NOTE: this is a single output register, not a storage array, so resetting it is
    // cheap; a real memory array would be left unreset.
    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/ad7768_cfg_seq.sv
// Register-configuration sequencer: writes each table entry through the dual-frame
// SPI engine, reads it back, retries on mismatch and reports done/error.
module ad7768_cfg_seq
    import ad7768_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 1023,
    parameter int VERIFY      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index,
    output logic [1:0] err_code,
    output logic       spi_start,
    output logic [7:0] spi_addr1,
    output logic       spi_rw1,
    output logic [7:0] spi_data1,
    output logic [7:0] spi_addr2,
    output logic       spi_rw2,
    output logic [7:0] spi_data2,
    input  logic       spi_end,
    input  logic [7:0] spi_rdata2
);

    localparam logic [3:0] LAST_IDX    = 4'(NUM_REGS - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
    localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYC);

    logic [7:0] state_q,     state_d;
    logic [3:0] index_q,     index_d;
    logic [2:0] retry_q,     retry_d;
    logic [9:0] timer_q,     timer_d;
    logic [7:0] rdata_q,     rdata_d;
    logic [7:0] addr_q,      addr_d;
    logic [7:0] data_q,      data_d;
    logic       rw2_q,       rw2_d;
    logic       error_q,     error_d;
    logic [3:0] err_index_q, err_index_d;
    logic [1:0] err_code_q,  err_code_d;

    logic [15:0] rom_entry;
    cfg_entry_t  rom_e;

    // The ROM is addressed with the next index so its registered output is
    // already valid for the current index when the FSM reaches LOAD.
    ad7768_cfg_rom u_rom (
        .clk   (clk),
        .rst   (rst),
        .idx   (index_d),
        .entry (rom_entry)
    );

    assign rom_e = cfg_entry_t'(rom_entry);

    always_comb begin
        // NOTE: every next-value signal gets its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw2_d       = rw2_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    index_d     = '0;
                    retry_d     = '0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                end
            end
            S_LOAD: begin
                addr_d  = rom_e.addr;
                data_d  = rom_e.data;
                rw2_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (spi_end) begin
                    rdata_d = spi_rdata2;
                    state_d = S_CHECK;
                end else if (timer_q == TIMEOUT_LIM) begin
                    state_d     = S_FAIL;
                    error_d     = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    err_index_d = index_q;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 10'd1;
                end
            end
            S_CHECK: begin
                if (VERIFY == 0 || rdata_q == data_q) begin
                    state_d = S_NEXT;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d     = S_FAIL;
                    error_d     = 1'b1;
                    err_code_d  = ERR_MISMATCH;
                    err_index_d = index_q;
                end
            end
            S_NEXT: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    retry_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rw2_q       <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw2_q       <= rw2_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
        end
    end

    assign busy      = (state_q == S_LOAD)  || (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK) || (state_q == S_NEXT);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign err_index = err_index_q;
    assign err_code  = err_code_q;
    assign spi_start = (state_q == S_ISSUE);
    assign spi_addr1 = addr_q;
    assign spi_rw1   = 1'b0;
    assign spi_data1 = data_q;
    assign spi_addr2 = addr_q;
    assign spi_rw2   = rw2_q;
    assign spi_data2 = 8'h00;

endmodule

// File: tb/tb_ad7768_cfg_seq.sv
// Self-checking bench for ad7768_cfg_seq: a verifying instance (A) and a
// no-verify instance (B), each with an SPI engine responder and job scoreboard.
module tb_ad7768_cfg_seq;

    localparam int NUM_REGS    = 3;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 1023;
    localparam int LAT         = 3;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } job_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst;

    logic       start_a, busy_a, done_a, error_a, spi_start_a, spi_rw1_a, spi_rw2_a, spi_end_a;
    logic [3:0] err_index_a;
    logic [1:0] err_code_a;
    logic [7:0] spi_addr1_a, spi_data1_a, spi_addr2_a, spi_data2_a, spi_rdata2_a;

    logic       start_b, busy_b, done_b, error_b, spi_start_b, spi_rw1_b, spi_rw2_b, spi_end_b;
    logic [3:0] err_index_b;
    logic [1:0] err_code_b;
    logic [7:0] spi_addr1_b, spi_data1_b, spi_addr2_b, spi_data2_b, spi_rdata2_b;

    ad7768_cfg_seq #(.NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY),
                     .TIMEOUT_CYC(TIMEOUT_CYC), .VERIFY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_index(err_index_a), .err_code(err_code_a),
        .spi_start(spi_start_a), .spi_addr1(spi_addr1_a), .spi_rw1(spi_rw1_a),
        .spi_data1(spi_data1_a), .spi_addr2(spi_addr2_a), .spi_rw2(spi_rw2_a),
        .spi_data2(spi_data2_a), .spi_end(spi_end_a), .spi_rdata2(spi_rdata2_a)
    );

    ad7768_cfg_seq #(.NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY),
                     .TIMEOUT_CYC(TIMEOUT_CYC), .VERIFY(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_index(err_index_b), .err_code(err_code_b),
        .spi_start(spi_start_b), .spi_addr1(spi_addr1_b), .spi_rw1(spi_rw1_b),
        .spi_data1(spi_data1_b), .spi_addr2(spi_addr2_b), .spi_rw2(spi_rw2_b),
        .spi_data2(spi_data2_b), .spi_end(spi_end_b), .spi_rdata2(spi_rdata2_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tbl_addr [3] = '{8'h04, 8'h07, 8'h00};
    logic [7:0] tbl_data [3] = '{8'h1B, 8'h01, 8'h00};

    job_t sb_a[$];
    job_t sb_b[$];
    int   jobs_a = 0, jobs_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    // Responder A behaviour knobs
    bit         hold_en  = 1'b0;
    logic [7:0] hold_addr = 8'h00;
    logic [7:0] bad_addr = 8'h00;
    logic [7:0] bad_val  = 8'h00;
    int         bad_left = 0;   // -1 = every attempt bad

    // SPI engine model for A: answers each job LAT cycles later, checks jobs against the scoreboard
    initial begin : resp_a
        int         pend;
        logic [7:0] resp;
        logic [7:0] cur_addr;
        job_t       exp;
        pend = 0; resp = '0; cur_addr = '0;
        spi_end_a = 1'b0; spi_rdata2_a = '0;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) done_cnt_a++;
            spi_end_a = 1'b0;
            if (rst === 1'b1) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        spi_end_a    = 1'b1;
                        spi_rdata2_a = resp;
                        n_cmp++;
                        if (spi_addr1_a !== cur_addr) begin
                            n_bad++;
                            $display("FAIL bus_stable_a: addr1 %h at spi_end, required %h", spi_addr1_a, cur_addr);
                        end
                    end
                end
                if (spi_start_a === 1'b1) begin
                    jobs_a++;
                    n_cmp++;
                    if (sb_a.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_job_a: addr1 %h data1 %h, required no job", spi_addr1_a, spi_data1_a);
                    end else begin
                        exp = sb_a.pop_front();
                        if ({spi_addr1_a, spi_data1_a, spi_addr2_a, spi_rw1_a, spi_rw2_a, spi_data2_a} !==
                            {exp.addr, exp.data, exp.addr, 1'b0, 1'b1, 8'h00}) begin
                            n_bad++;
                            $display("FAIL job_a: a1=%h d1=%h a2=%h rw1=%b rw2=%b d2=%h, required a1=%h d1=%h a2=%h rw1=0 rw2=1 d2=00",
                                     spi_addr1_a, spi_data1_a, spi_addr2_a, spi_rw1_a, spi_rw2_a, spi_data2_a,
                                     exp.addr, exp.data, exp.addr);
                        end
                    end
                    cur_addr = spi_addr1_a;
                    if (!(hold_en && spi_addr1_a == hold_addr)) begin
                        if (bad_left != 0 && spi_addr1_a == bad_addr) begin
                            resp = bad_val;
                            if (bad_left > 0) bad_left--;
                        end else begin
                            resp = spi_data1_a;
                        end
                        pend = LAT;
                    end
                end
            end
        end
    end

    // SPI engine model for B: always returns a byte that differs from the written data
    initial begin : resp_b
        int   pend;
        job_t exp;
        pend = 0;
        spi_end_b = 1'b0; spi_rdata2_b = '0;
        forever begin
            @(negedge clk);
            if (done_b === 1'b1) done_cnt_b++;
            spi_end_b = 1'b0;
            if (rst === 1'b1) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) spi_end_b = 1'b1;
                end
                if (spi_start_b === 1'b1) begin
                    jobs_b++;
                    n_cmp++;
                    if (sb_b.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_job_b: addr1 %h data1 %h, required no job", spi_addr1_b, spi_data1_b);
                    end else begin
                        exp = sb_b.pop_front();
                        if ({spi_addr1_b, spi_data1_b, spi_rw1_b, spi_rw2_b} !== {exp.addr, exp.data, 1'b0, 1'b1}) begin
                            n_bad++;
                            $display("FAIL job_b: a1=%h d1=%h rw1=%b rw2=%b, required a1=%h d1=%h rw1=0 rw2=1",
                                     spi_addr1_b, spi_data1_b, spi_rw1_b, spi_rw2_b, exp.addr, exp.data);
                        end
                    end
                    spi_rdata2_b = ~spi_data1_b ^ 8'h5A;
                    pend = 2;
                end
            end
        end
    end

    task automatic push_a(input int idx);
        job_t j;
        j.addr = tbl_addr[idx];
        j.data = tbl_data[idx];
        sb_a.push_back(j);
    endtask

    task automatic push_b(input int idx);
        job_t j;
        j.addr = tbl_addr[idx];
        j.data = tbl_data[idx];
        sb_b.push_back(j);
    endtask

    task automatic wait_end_a(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || error_a === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_end_a: no done/error within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_a, done_a, error_a, err_index_a, err_code_a, spi_start_a, spi_addr1_a, spi_rw1_a,
             spi_data1_a, spi_addr2_a, spi_rw2_a, spi_data2_a, busy_b, spi_start_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b idx=%h code=%h start=%b a1=%h d1=%h a2=%h rw2=%b d2=%h, required all 0",
                     busy_a, done_a, error_a, err_index_a, err_code_a, spi_start_a, spi_addr1_a,
                     spi_data1_a, spi_addr2_a, spi_rw2_a, spi_data2_a);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || spi_start_a !== 1'b0) begin
            n_bad++;
            $display("FAIL start_with_rst: busy=%b spi_start=%b, required 0 0", busy_a, spi_start_a);
        end
    endtask

    task automatic test_happy;
        int j0, d0, gap;
        bit hit;
        j0 = jobs_a; d0 = done_cnt_a;
        push_a(0); push_a(1); push_a(2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL busy_rise: busy=%b, required 1", busy_a);
        end
        @(negedge clk);
        n_cmp++;
        if (spi_start_a !== 1'b1) begin
            n_bad++; $display("FAIL first_start_latency: spi_start=%b two cycles after start, required 1", spi_start_a);
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (spi_start_a !== 1'b1 && gap < 100);
        n_cmp++;
        if (gap !== LAT + 4) begin
            n_bad++; $display("FAIL entry_gap: %0d cycles between jobs, required %0d", gap, LAT + 4);
        end
        wait_end_a(200, hit);
        if (hit) begin
            n_cmp++;
            if (done_a !== 1'b1 || error_a !== 1'b0 || busy_a !== 1'b0) begin
                n_bad++; $display("FAIL happy_end: done=%b error=%b busy=%b, required 1 0 0", done_a, error_a, busy_a);
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (jobs_a - j0 !== 3 || done_cnt_a - d0 !== 1 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL happy_counts: jobs=%0d done_cycles=%0d pending=%0d, required 3 1 0",
                              jobs_a - j0, done_cnt_a - d0, sb_a.size());
        end
    endtask

    task automatic test_mismatch;
        int j0, d0;
        bit hit;
        j0 = jobs_a; d0 = done_cnt_a;
        bad_addr = 8'h07; bad_val = 8'hFF; bad_left = 1;
        push_a(0); push_a(1); push_a(1); push_a(2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_end_a(300, hit);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (jobs_a - j0 !== 4 || done_cnt_a - d0 !== 1 || error_a !== 1'b0 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL single_mismatch: jobs=%0d done_cycles=%0d error=%b pending=%0d, required 4 1 0 0",
                              jobs_a - j0, done_cnt_a - d0, error_a, sb_a.size());
        end
        bad_left = 0;
    endtask

    task automatic test_retry_exhaust;
        int j0, d0;
        bit hit;
        j0 = jobs_a; d0 = done_cnt_a;
        bad_addr = 8'h00; bad_val = 8'hAA; bad_left = -1;
        push_a(0); push_a(1); push_a(2); push_a(2); push_a(2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_end_a(300, hit);
        n_cmp++;
        if (error_a !== 1'b1 || err_index_a !== 4'd2 || err_code_a !== 2'd1 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL retry_exhaust: error=%b err_index=%0d err_code=%0d busy=%b, required 1 2 1 0",
                              error_a, err_index_a, err_code_a, busy_a);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (jobs_a - j0 !== 5 || done_cnt_a - d0 !== 0 || error_a !== 1'b1 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL retry_counts: jobs=%0d done_cycles=%0d error=%b pending=%0d, required 5 0 1 0",
                              jobs_a - j0, done_cnt_a - d0, error_a, sb_a.size());
        end
        bad_left = 0;
    endtask

    task automatic test_timeout;
        int cnt, d0;
        d0 = done_cnt_a;
        hold_en = 1'b1; hold_addr = 8'h04;
        push_a(0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        while (spi_start_a !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (error_a !== 1'b1 && cnt < 1200);
        n_cmp++;
        if (cnt !== TIMEOUT_CYC + 2) begin
            n_bad++; $display("FAIL timeout_latency: error %0d cycles after spi_start, required %0d", cnt, TIMEOUT_CYC + 2);
        end
        n_cmp++;
        if (err_code_a !== 2'd2 || err_index_a !== 4'd0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL timeout_code: err_code=%0d err_index=%0d busy=%b, required 2 0 0",
                              err_code_a, err_index_a, busy_a);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt_a - d0 !== 0 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL timeout_counts: done_cycles=%0d pending=%0d, required 0 0", done_cnt_a - d0, sb_a.size());
        end
        hold_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int j0, cnt;
        bit hit;
        j0 = jobs_a;
        hold_en = 1'b1; hold_addr = 8'h07;
        push_a(0); push_a(1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_cmp++;
        if (error_a !== 1'b0 || err_code_a !== 2'd0) begin
            n_bad++; $display("FAIL start_clears_error: error=%b err_code=%0d, required 0 0", error_a, err_code_a);
        end
        cnt = 0;
        while (jobs_a - j0 < 2 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || spi_start_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_idle: busy=%b spi_start=%b, required 0 0", busy_a, spi_start_a);
        end
        hold_en = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (jobs_a - j0 !== 2 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL reset_mid_jobs: jobs=%0d pending=%0d, required 2 0", jobs_a - j0, sb_a.size());
        end
        push_a(0); push_a(1); push_a(2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_end_a(300, hit);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (jobs_a - j0 !== 5 || error_a !== 1'b0 || sb_a.size() !== 0) begin
            n_bad++; $display("FAIL reset_mid_restart: jobs=%0d error=%b pending=%0d, required 5 0 0",
                              jobs_a - j0, error_a, sb_a.size());
        end
    endtask

    task automatic test_back_to_back;
        int j0, d0;
        bit hit;
        j0 = jobs_b; d0 = done_cnt_b;
        push_b(0); push_b(1); push_b(2);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (6) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_b === 1'b1 || error_b === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit || done_b !== 1'b1 || error_b !== 1'b0) begin
            n_bad++; $display("FAIL noverify_end: seen=%b done=%b error=%b, required 1 1 0", hit, done_b, error_b);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (jobs_b - j0 !== 3 || done_cnt_b - d0 !== 1 || busy_b !== 1'b0 || sb_b.size() !== 0) begin
            n_bad++; $display("FAIL noverify_counts: jobs=%0d done_cycles=%0d busy=%b pending=%0d, required 3 1 0 0",
                              jobs_b - j0, done_cnt_b - d0, busy_b, sb_b.size());
        end
    endtask

    initial begin : watchdog
        #(40 * 50000);
        $display("FAIL watchdog: simulation exceeded 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        test_reset();
        test_happy();
        test_mismatch();
        test_retry_exhaust();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
